// File: rtl/rob_multi_pkg.sv
// -----------------------------------------------------------------------------
// rob_multi_pkg
// Shared types and defaults for the multi-issue reorder buffer.
//   rob_alloc_t  : per-slot allocation payload from rename
//   rob_commit_t : per-slot retire payload to free list / store buffer
//   rob_entry_t  : one ROB storage entry (status bits + resolved target + payload)
// PC and physical-register widths are fixed here because the packed struct
// layouts depend on them.
// -----------------------------------------------------------------------------
package rob_multi_pkg;

  localparam int ROB_ENTRY_DEF    = 16;
  localparam int ISSUE_WIDTH_DEF  = 2;
  localparam int COMMIT_WIDTH_DEF = 2;
  localparam int NUM_WB_DEF       = 4;
  localparam int ROB_PC_W         = 16;
  localparam int ROB_PREG_W       = 6;

  typedef struct packed {
    logic [ROB_PC_W-1:0]   pc;
    logic                  w_v;
    logic                  is_store;
    logic                  is_branch;
    logic [ROB_PREG_W-1:0] alloc_reg;
    logic [ROB_PREG_W-1:0] freed_reg;
  } rob_alloc_t;

  typedef struct packed {
    logic                  w_v;
    logic                  is_store;
    logic [ROB_PREG_W-1:0] alloc_reg;
    logic [ROB_PREG_W-1:0] freed_reg;
  } rob_commit_t;

  typedef struct packed {
    logic                valid;
    logic                done;
    logic                mispred;
    logic [ROB_PC_W-1:0] target;
    rob_alloc_t          info;
  } rob_entry_t;

  localparam int ALLOC_W  = $bits(rob_alloc_t);
  localparam int COMMIT_W = $bits(rob_commit_t);

  function automatic rob_commit_t to_commit(input rob_alloc_t a);
    rob_commit_t c;
    c.w_v       = a.w_v;
    c.is_store  = a.is_store;
    c.alloc_reg = a.alloc_reg;
    c.freed_reg = a.freed_reg;
    return c;
  endfunction

endpackage

// File: rtl/rob_multi_commit_sel.sv
// -----------------------------------------------------------------------------
// rob_commit_sel
// Combinational scan of the COMMIT_WIDTH entries starting at the ROB head.
// A slot retires while every older slot in the window retired, was not a
// mispredicted branch and was not a store (one store per cycle).
//   win_i          : head window, slot 0 = oldest
//   commit_valid_o : retiring slots, contiguous from bit 0
//   retire_cnt_o   : number of retiring slots
//   sb_pop_o       : a retiring slot is a store
//   flush_o        : a retiring slot is a mispredicted branch
//   redirect_pc_o  : resolved target of that branch
// -----------------------------------------------------------------------------
module rob_commit_sel
  import rob_multi_pkg::*;
#(
  parameter int COMMIT_WIDTH = COMMIT_WIDTH_DEF,
  parameter int CNT_W        = 5
) (
  input  rob_entry_t [COMMIT_WIDTH-1:0] win_i,
  output logic       [COMMIT_WIDTH-1:0] commit_valid_o,
  output logic       [CNT_W-1:0]        retire_cnt_o,
  output logic                          sb_pop_o,
  output logic                          flush_o,
  output logic       [ROB_PC_W-1:0]     redirect_pc_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic scan_run;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
    commit_valid_o = '0;
    retire_cnt_o   = '0;
    sb_pop_o       = 1'b0;
    flush_o        = 1'b0;
    redirect_pc_o  = '0;
    scan_run       = 1'b1;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (scan_run && win_i[k].valid && win_i[k].done) begin
        commit_valid_o[k] = 1'b1;
        retire_cnt_o      = retire_cnt_o + CNT_ONE;
        if (win_i[k].info.is_store) begin
          sb_pop_o = 1'b1;
          scan_run = 1'b0;
        end
        if (win_i[k].mispred) begin
          flush_o       = 1'b1;
          redirect_pc_o = win_i[k].target;
          scan_run      = 1'b0;
        end
      end else begin
        scan_run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_multi.sv
// -----------------------------------------------------------------------------
// rob_multi
// Multi-issue reorder buffer: ISSUE_WIDTH allocations, NUM_WB writebacks and
// COMMIT_WIDTH in-order retirements per cycle. A retiring mispredicted branch
// commits itself and squashes every younger entry.
//   clk_i, reset_i  : clock, synchronous active-low reset
//   alloc_*         : rename-side allocation (valid, payload, ready, tags)
//   wb_*            : completion bus (valid, tag, mispredict, correct target)
//   commit_*        : retire slots to free list; sb_pop_o to the store buffer
//   flush_o         : younger entries squashed, redirect_pc_o to the front end
//   count_o         : occupied entries
// -----------------------------------------------------------------------------
module rob_multi
  import rob_multi_pkg::*;
#(
  parameter int ROB_ENTRY    = ROB_ENTRY_DEF,
  parameter int ISSUE_WIDTH  = ISSUE_WIDTH_DEF,
  parameter int COMMIT_WIDTH = COMMIT_WIDTH_DEF,
  parameter int NUM_WB       = NUM_WB_DEF,
  parameter int PC_W         = ROB_PC_W,
  parameter int PREG_W       = ROB_PREG_W,
  parameter int TAG_W        = $clog2(ROB_ENTRY)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [ISSUE_WIDTH-1:0]           alloc_valid_i,
  input  logic [ISSUE_WIDTH*ALLOC_W-1:0]   alloc_entry_i,
  output logic                             alloc_ready_o,
  output logic [ISSUE_WIDTH*TAG_W-1:0]     alloc_tag_o,
  input  logic [NUM_WB-1:0]                wb_valid_i,
  input  logic [NUM_WB*TAG_W-1:0]          wb_tag_i,
  input  logic [NUM_WB-1:0]                wb_mispred_i,
  input  logic [NUM_WB*PC_W-1:0]           wb_target_i,
  output logic [COMMIT_WIDTH-1:0]          commit_valid_o,
  output logic [COMMIT_WIDTH*COMMIT_W-1:0] commit_entry_o,
  output logic                             sb_pop_o,
  output logic                             flush_o,
  output logic [PC_W-1:0]                  redirect_pc_o,
  output logic [TAG_W:0]                   count_o
);

  localparam logic [TAG_W:0] CNT_ONE = (TAG_W+1)'(1);

  rob_entry_t       entries_q [ROB_ENTRY];
  rob_entry_t       entries_d [ROB_ENTRY];
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  rob_entry_t [COMMIT_WIDTH-1:0] win;
  logic [COMMIT_WIDTH-1:0]       sel_valid;
  logic [TAG_W:0]                n_ret, n_alloc;
  logic                          sel_sb_pop, sel_flush, flush_act;
  logic [PC_W-1:0]               sel_redirect;
  logic [TAG_W-1:0]              wb_idx, alloc_idx;

  always_comb begin
    for (int k = 0; k < COMMIT_WIDTH; k++) win[k] = entries_q[head_q + TAG_W'(k)];
  end

  rob_commit_sel #(
    .COMMIT_WIDTH (COMMIT_WIDTH),
    .CNT_W        (TAG_W + 1)
  ) u_commit_sel (
    .win_i          (win),
    .commit_valid_o (sel_valid),
    .retire_cnt_o   (n_ret),
    .sb_pop_o       (sel_sb_pop),
    .flush_o        (sel_flush),
    .redirect_pc_o  (sel_redirect)
  );

  // Retire-side outputs are held at zero while reset is asserted so a reset
  // in mid-stream never leaks a commit to the free list or store buffer.
  assign flush_act      = sel_flush & reset_i;
  assign commit_valid_o = reset_i ? sel_valid : '0;
  assign sb_pop_o       = sel_sb_pop & reset_i;
  assign flush_o        = flush_act;
  assign redirect_pc_o  = flush_act ? sel_redirect : '0;
  assign count_o        = count_q;

  // Readiness uses the registered count: slots freed by this cycle's commit
  // are not reusable until next cycle.
  assign alloc_ready_o = (int'(count_q) <= ROB_ENTRY - ISSUE_WIDTH) && !flush_act;

  always_comb begin
    for (int k = 0; k < ISSUE_WIDTH; k++) alloc_tag_o[k*TAG_W +: TAG_W] = tail_q + TAG_W'(k);
    for (int k = 0; k < COMMIT_WIDTH; k++)
      commit_entry_o[k*COMMIT_W +: COMMIT_W] = commit_valid_o[k] ? to_commit(win[k].info) : '0;
  end

  always_comb begin
    entries_d = entries_q;
    n_alloc   = '0;
    wb_idx    = '0;
    alloc_idx = '0;

    // Highest port first so the lowest port index wins a same-tag collision.
    // Validity is checked on registered state: an entry allocated this cycle
    // cannot be written back until the next one.
    for (int p = NUM_WB - 1; p >= 0; p--) begin
      wb_idx = wb_tag_i[p*TAG_W +: TAG_W];
      if (wb_valid_i[p] && entries_q[wb_idx].valid && !entries_q[wb_idx].done) begin
        entries_d[wb_idx].done    = 1'b1;
        entries_d[wb_idx].mispred = wb_mispred_i[p];
        entries_d[wb_idx].target  = wb_target_i[p*PC_W +: PC_W];
      end
    end

    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (commit_valid_o[k]) begin
        entries_d[head_q + TAG_W'(k)].valid = 1'b0;
        entries_d[head_q + TAG_W'(k)].done  = 1'b0;
      end
    end

    // Retired entries are already cleared, so clearing everything leaves
    // exactly the younger entries squashed; this also drops same-cycle writebacks.
    if (flush_act) begin
      for (int i = 0; i < ROB_ENTRY; i++) begin
        entries_d[i].valid = 1'b0;
        entries_d[i].done  = 1'b0;
      end
    end

    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      if (alloc_ready_o && alloc_valid_i[k]) begin
        alloc_idx                    = tail_q + TAG_W'(k);
        entries_d[alloc_idx].valid   = 1'b1;
        entries_d[alloc_idx].done    = 1'b0;
        entries_d[alloc_idx].mispred = 1'b0;
        entries_d[alloc_idx].target  = '0;
        entries_d[alloc_idx].info    = rob_alloc_t'(alloc_entry_i[k*ALLOC_W +: ALLOC_W]);
        n_alloc                      = n_alloc + CNT_ONE;
      end
    end

    head_d = head_q + n_ret[TAG_W-1:0];
    if (flush_act) begin
      tail_d  = head_d;
      count_d = '0;
    end else begin
      tail_d  = tail_q + n_alloc[TAG_W-1:0];
      count_d = count_q + n_alloc - n_ret;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      // NOTE: only the valid/done bits of the storage array are reset; the payload is don't-care until allocated.
      for (int i = 0; i < ROB_ENTRY; i++) begin
        entries_q[i].valid <= 1'b0;
        entries_q[i].done  <= 1'b0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: tb/tb_rob_multi.sv
module tb_rob_multi;
  import rob_multi_pkg::*;

  localparam int ROB = 16, IW = 2, CW = 2, NWB = 4, TW = 4, PCW = ROB_PC_W;

  logic                   clk = 1'b0;
  logic                   reset_i;
  logic [IW-1:0]          alloc_valid_i;
  logic [IW*ALLOC_W-1:0]  alloc_entry_i;
  logic                   alloc_ready_o;
  logic [IW*TW-1:0]       alloc_tag_o;
  logic [NWB-1:0]         wb_valid_i;
  logic [NWB*TW-1:0]      wb_tag_i;
  logic [NWB-1:0]         wb_mispred_i;
  logic [NWB*PCW-1:0]     wb_target_i;
  logic [CW-1:0]          commit_valid_o;
  logic [CW*COMMIT_W-1:0] commit_entry_o;
  logic                   sb_pop_o;
  logic                   flush_o;
  logic [PCW-1:0]         redirect_pc_o;
  logic [TW:0]            count_o;

  always #5 clk = ~clk;

  rob_multi #(
    .ROB_ENTRY(ROB), .ISSUE_WIDTH(IW), .COMMIT_WIDTH(CW), .NUM_WB(NWB),
    .PC_W(PCW), .PREG_W(ROB_PREG_W), .TAG_W(TW)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .alloc_valid_i(alloc_valid_i), .alloc_entry_i(alloc_entry_i),
    .alloc_ready_o(alloc_ready_o), .alloc_tag_o(alloc_tag_o),
    .wb_valid_i(wb_valid_i), .wb_tag_i(wb_tag_i),
    .wb_mispred_i(wb_mispred_i), .wb_target_i(wb_target_i),
    .commit_valid_o(commit_valid_o), .commit_entry_o(commit_entry_o),
    .sb_pop_o(sb_pop_o), .flush_o(flush_o),
    .redirect_pc_o(redirect_pc_o), .count_o(count_o)
  );

  typedef struct { int tag; rob_commit_t ce; } sb_rec_t;
  typedef struct {
    int       n_alloc;
    int       n_wb;
    int       wb_base;
    logic [1:0] exp_cv;
    int       exp_cnt;
    logic     exp_rdy;
  } vec_t;

  sb_rec_t        sbq[$];
  logic           exp_mis [ROB];
  logic [PCW-1:0] exp_tgt [ROB];
  int             m_tail, m_count, seq_no;
  int             n_checks = 0, n_fail = 0;
  logic           mon_en = 1'b0;
  vec_t           vecs [10];

  sb_rec_t        mon_rec;
  logic           mon_st, mon_ef;
  logic [PCW-1:0] mon_epc;
  int             mon_ft;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic rob_alloc_t mk_entry(input int s, input logic st, input logic br);
    rob_alloc_t a;
    logic [31:0] sv;
    sv          = s;
    a.pc        = PCW'(s * 4);
    a.w_v       = sv[0];
    a.is_store  = st;
    a.is_branch = br;
    a.alloc_reg = sv[ROB_PREG_W-1:0];
    a.freed_reg = ~sv[ROB_PREG_W-1:0];
    return a;
  endfunction

  task automatic clear_inputs();
    alloc_valid_i = '0; alloc_entry_i = '0;
    wb_valid_i = '0; wb_tag_i = '0; wb_mispred_i = '0; wb_target_i = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  // Drives n allocations and records the expected retire payload in program order.
  task automatic set_alloc(input int n, input logic [1:0] st, input logic [1:0] br);
    rob_alloc_t a;
    sb_rec_t    r;
    check("alloc_ready", alloc_ready_o, 1);
    for (int k = 0; k < n; k++) begin
      a = mk_entry(seq_no, st[k], br[k]);
      seq_no++;
      alloc_valid_i[k] = 1'b1;
      alloc_entry_i[k*ALLOC_W +: ALLOC_W] = a;
      check("alloc_tag", alloc_tag_o[k*TW +: TW], m_tail);
      r.tag          = m_tail;
      r.ce.w_v       = a.w_v;
      r.ce.is_store  = a.is_store;
      r.ce.alloc_reg = a.alloc_reg;
      r.ce.freed_reg = a.freed_reg;
      sbq.push_back(r);
      exp_mis[m_tail] = 1'b0;
      m_tail  = (m_tail + 1) % ROB;
      m_count++;
    end
  endtask

  task automatic set_wb(input int p, input int tag, input logic mis, input logic [PCW-1:0] tgt);
    wb_valid_i[p]              = 1'b1;
    wb_tag_i[p*TW +: TW]       = TW'(tag);
    wb_mispred_i[p]            = mis;
    wb_target_i[p*PCW +: PCW]  = tgt;
    if (mis) begin
      exp_mis[tag] = 1'b1;
      exp_tgt[tag] = tgt;
    end
  endtask

  task automatic do_reset();
    mon_en  = 1'b0;
    reset_i = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1;
    check("rst_count", count_o, 0);
    check("rst_commit_valid", commit_valid_o, 0);
    check("rst_flush", flush_o, 0);
    check("rst_sb_pop", sb_pop_o, 0);
    check("rst_redirect", redirect_pc_o, 0);
    check("rst_ready", alloc_ready_o, 1);
    check("rst_tag0", alloc_tag_o[0 +: TW], 0);
    check("rst_tag1", alloc_tag_o[TW +: TW], 1);
    reset_i = 1'b1;
    sbq.delete();
    m_tail  = 0;
    m_count = 0;
    mon_en  = 1'b1;
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (m_count > 0 && c < budget) begin
      tick();
      c++;
    end
    check("drain_count", count_o, 0);
  endtask

  // Scoreboard: every retiring slot must be the next allocated instruction.
  always @(negedge clk) begin
    if (mon_en && reset_i) begin
      mon_st = 1'b0; mon_ef = 1'b0; mon_epc = '0; mon_ft = 0;
      for (int k = 0; k < CW; k++) begin
        if (commit_valid_o[k] && !mon_ef) begin
          if (sbq.size() == 0) begin
            check("commit_without_alloc", commit_valid_o[k], 0);
          end else begin
            mon_rec = sbq.pop_front();
            check("commit_entry", commit_entry_o[k*COMMIT_W +: COMMIT_W], mon_rec.ce);
            if (mon_rec.ce.is_store) mon_st = 1'b1;
            if (exp_mis[mon_rec.tag]) begin
              mon_ef  = 1'b1;
              mon_epc = exp_tgt[mon_rec.tag];
              mon_ft  = mon_rec.tag;
            end
            m_count--;
          end
        end else if (commit_valid_o[k]) begin
          check("commit_after_flush_slot", commit_valid_o[k], 0);
        end
      end
      if (commit_valid_o != '0 || flush_o) begin
        check("sb_pop", sb_pop_o, mon_st);
        check("flush", flush_o, mon_ef);
        if (mon_ef) check("redirect_pc", redirect_pc_o, mon_epc);
      end
      if (mon_ef) begin
        sbq.delete();
        m_count = 0;
        m_tail  = (mon_ft + 1) % ROB;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b0;
    seq_no  = 0;
    for (int i = 0; i < ROB; i++) begin exp_mis[i] = 1'b0; exp_tgt[i] = '0; end
    clear_inputs();
    @(posedge clk);
    do_reset();

    // Fill to full with 2-wide allocation, then retire the two oldest.
    for (int i = 0; i < 8; i++) vecs[i] = '{2, 0, 0, 2'b00, 2*(i+1), (i < 7)};
    vecs[8] = '{0, 2, 0, 2'b11, 16, 1'b0};
    vecs[9] = '{0, 0, 0, 2'b00, 14, 1'b1};
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].n_alloc > 0) set_alloc(vecs[i].n_alloc, 2'b00, 2'b00);
      for (int j = 0; j < vecs[i].n_wb; j++) set_wb(j, vecs[i].wb_base + j, 1'b0, '0);
      tick();
      check($sformatf("vec%0d_commit_valid", i), commit_valid_o, vecs[i].exp_cv);
      check($sformatf("vec%0d_count", i), count_o, vecs[i].exp_cnt);
      check($sformatf("vec%0d_ready", i), alloc_ready_o, vecs[i].exp_rdy);
    end

    // Head (tag 2) not done: younger completions must wait.
    set_wb(0, 3, 1'b0, '0); set_wb(1, 4, 1'b0, '0); set_wb(2, 5, 1'b0, '0);
    tick();
    check("gap_no_commit", commit_valid_o, 2'b00);
    set_wb(0, 2, 1'b0, '0);
    tick();
    check("gap_commit_a", commit_valid_o, 2'b11);
    tick();
    check("gap_commit_b", commit_valid_o, 2'b11);
    tick();
    check("gap_idle", commit_valid_o, 2'b00);
    check("gap_count", count_o, 10);

    // Reset with 10 entries, head pair ready to retire.
    set_wb(0, 6, 1'b0, '0); set_wb(1, 7, 1'b0, '0);
    tick();
    check("pre_reset_commit", commit_valid_o, 2'b11);
    mon_en  = 1'b0;
    reset_i = 1'b0;
    #1;
    check("reset_gate_commit", commit_valid_o, 2'b00);
    check("reset_gate_sb_pop", sb_pop_o, 0);
    do_reset();

    // Two adjacent stores: one per cycle.
    set_alloc(2, 2'b11, 2'b00);
    tick();
    set_wb(0, 0, 1'b0, '0); set_wb(1, 1, 1'b0, '0);
    tick();
    check("store_a_valid", commit_valid_o, 2'b01);
    check("store_a_pop", sb_pop_o, 1);
    tick();
    check("store_b_valid", commit_valid_o, 2'b01);
    check("store_b_pop", sb_pop_o, 1);
    tick();
    check("store_idle", commit_valid_o, 2'b00);
    check("store_count", count_o, 0);

    // Mispredicted branch at tag 5, younger 6..9 present.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_alloc(2, 2'b00, (i == 2) ? 2'b10 : 2'b00);
      tick();
    end
    for (int p = 0; p < 4; p++) set_wb(p, p, 1'b0, '0);
    tick();
    check("br_commit_01", commit_valid_o, 2'b11);
    set_wb(0, 4, 1'b0, '0); set_wb(1, 5, 1'b1, 16'h0040);
    set_wb(2, 6, 1'b0, '0); set_wb(3, 7, 1'b0, '0);
    tick();
    check("br_commit_23", commit_valid_o, 2'b11);
    check("br_no_flush_yet", flush_o, 0);
    set_wb(0, 8, 1'b0, '0);
    tick();
    check("br_commit_45", commit_valid_o, 2'b11);
    check("br_flush", flush_o, 1);
    check("br_redirect", redirect_pc_o, 16'h0040);
    check("br_ready_blocked", alloc_ready_o, 0);
    tick();
    check("br_count_after", count_o, 0);
    check("br_next_tag", alloc_tag_o[0 +: TW], 6);
    check("br_ready_after", alloc_ready_o, 1);
    check("br_flush_clear", flush_o, 0);
    set_alloc(2, 2'b00, 2'b00);
    tick();
    check("br_realloc_not_done", commit_valid_o, 2'b00);
    check("br_realloc_count", count_o, 2);
    set_wb(0, 6, 1'b0, '0); set_wb(1, 7, 1'b0, '0);
    tick();
    drain(10);

    // Wrap-around: move head to 14, then allocate 14,15,0,1.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      set_alloc(2, 2'b00, 2'b00);
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      for (int p = 0; p < 4; p++) if (4*c + p < 14) set_wb(p, 4*c + p, 1'b0, '0);
      tick();
    end
    drain(20);
    set_alloc(2, 2'b00, 2'b00);
    tick();
    set_alloc(2, 2'b00, 2'b00);
    tick();
    check("wrap_count", count_o, 4);
    set_wb(0, 14, 1'b0, '0); set_wb(1, 15, 1'b0, '0);
    set_wb(2, 0, 1'b0, '0);  set_wb(3, 1, 1'b0, '0);
    tick();
    check("wrap_commit_a", commit_valid_o, 2'b11);
    tick();
    check("wrap_commit_b", commit_valid_o, 2'b11);
    tick();
    check("wrap_idle", commit_valid_o, 2'b00);
    check("wrap_count_end", count_o, 0);
    check("wrap_queue_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
